// File: rtl/snake_grid_engine.sv
// Snake state holder and 2-stage per-pixel classifier (head/body/fruit/empty).
// Define SNAKE_WRAP_EN to wrap the head around grid edges instead of colliding.
module snake_grid_engine #(
    parameter int GRID_W    = 80,
    parameter int GRID_H    = 60,
    parameter int TILE_LOG2 = 3,
    parameter int MAX_LEN   = 16,
    parameter int COORD_W   = 7,
    parameter int LEN_W     = 5,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic                 clock_25,
    input  logic                 reset,
    input  logic [9:0]           X,
    input  logic [9:0]           Y,
    input  logic [1:0]           dir,
    input  logic                 step,
    input  logic                 grow,
    input  logic [COORD_W-1:0]   fruit_x,
    input  logic [COORD_W-1:0]   fruit_y,
    output logic                 game_area,
    output logic [1:0]           selected_figure,
    output logic [TILE_LOG2-1:0] x_local,
    output logic [TILE_LOG2-1:0] y_local,
    output logic [COORD_W-1:0]   snake_head_x,
    output logic [COORD_W-1:0]   snake_head_y,
    output logic [LEN_W-1:0]     snake_length,
    output logic                 step_ack,
    output logic                 collision
);

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        FIG_EMPTY = 2'b00,
        FIG_HEAD  = 2'b01,
        FIG_BODY  = 2'b10,
        FIG_FRUIT = 2'b11
    } fig_e;

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int GRID_PIX_W = GRID_W << TILE_LOG2;
    localparam int GRID_PIX_H = GRID_H << TILE_LOG2;
    // The visible grid is clipped to the active video area.
    localparam logic [9:0] PIX_W   = 10'((GRID_PIX_W < H_ACTIVE) ? GRID_PIX_W : H_ACTIVE);
    localparam logic [9:0] PIX_H   = 10'((GRID_PIX_H < V_ACTIVE) ? GRID_PIX_H : V_ACTIVE);
    localparam logic [9:0] APPLY_Y = 10'(V_ACTIVE);

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] START_X = COORD_W'(GRID_W / 2);
    localparam logic [COORD_W-1:0] START_Y = COORD_W'(GRID_H / 2);
    localparam logic [COORD_W-1:0] ONE_C   = COORD_W'(1);
    localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);

    // ------------------------------------------------------------------
    // Snake state
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] seg_x_q [MAX_LEN];
    logic [COORD_W-1:0] seg_x_d [MAX_LEN];
    logic [COORD_W-1:0] seg_y_q [MAX_LEN];
    logic [COORD_W-1:0] seg_y_d [MAX_LEN];
    logic [LEN_W-1:0]   len_q, len_d;
    dir_e               heading_q, heading_d;
    dir_e               pend_dir_q, pend_dir_d;
    logic               pending_q, pending_d;
    logic               pend_grow_q, pend_grow_d;
    logic               collision_q, collision_d;
    logic               step_ack_q, step_ack_d;

    // Move evaluation
    logic               apply_now;
    dir_e               move_dir;
    logic               grow_eff;
    logic               wall_hit;
    logic               self_hit;
    logic [COORD_W-1:0] new_x, new_y;

    assign apply_now = pending_q && (X == 10'd0) && (Y == APPLY_Y);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        move_dir = ((pend_dir_q ^ heading_q) == 2'b10) ? heading_q : pend_dir_q;
        grow_eff = pend_grow_q && (len_q < LEN_MAX);
        wall_hit = 1'b0;
        new_x    = seg_x_q[0];
        new_y    = seg_y_q[0];

        case (move_dir)
            DIR_RIGHT: begin
                if (seg_x_q[0] == X_LAST) begin
                    wall_hit = 1'b1;
                    new_x    = '0;
                end else begin
                    new_x = seg_x_q[0] + ONE_C;
                end
            end
            DIR_LEFT: begin
                if (seg_x_q[0] == '0) begin
                    wall_hit = 1'b1;
                    new_x    = X_LAST;
                end else begin
                    new_x = seg_x_q[0] - ONE_C;
                end
            end
            DIR_DOWN: begin
                if (seg_y_q[0] == Y_LAST) begin
                    wall_hit = 1'b1;
                    new_y    = '0;
                end else begin
                    new_y = seg_y_q[0] + ONE_C;
                end
            end
            default: begin
                if (seg_y_q[0] == '0) begin
                    wall_hit = 1'b1;
                    new_y    = Y_LAST;
                end else begin
                    new_y = seg_y_q[0] - ONE_C;
                end
            end
        endcase

        // The tail vacates its tile this move unless the snake grows.
        self_hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((grow_eff ? (LEN_W'(i) < len_q) : (LEN_W'(i + 1) < len_q)) &&
                (seg_x_q[i] == new_x) && (seg_y_q[i] == new_y)) begin
                self_hit = 1'b1;
            end
        end
    end

    always_comb begin
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        len_d       = len_q;
        heading_d   = heading_q;
        pending_d   = pending_q;
        pend_dir_d  = pend_dir_q;
        pend_grow_d = pend_grow_q;
        collision_d = collision_q;
        step_ack_d  = 1'b0;

        if (pending_q) begin
            if (apply_now) begin
                pending_d  = 1'b0;
                step_ack_d = 1'b1;
                if ((wall_hit && !WRAP) || self_hit) begin
                    collision_d = 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_d[i] = seg_x_q[i-1];
                        seg_y_d[i] = seg_y_q[i-1];
                    end
                    seg_x_d[0] = new_x;
                    seg_y_d[0] = new_y;
                    heading_d  = move_dir;
                    len_d      = len_q + LEN_W'(grow_eff);
                end
            end
        end else if (step && !collision_q) begin
            pending_d   = 1'b1;
            pend_dir_d  = dir_e'(dir);
            pend_grow_d = grow;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            // NOTE: only the two live segments are reset; slots past the length are never read, so the rest of the store stays reset-free.
            seg_x_q[0]  <= START_X;
            seg_y_q[0]  <= START_Y;
            seg_x_q[1]  <= START_X - ONE_C;
            seg_y_q[1]  <= START_Y;
            len_q       <= LEN_W'(2);
            heading_q   <= DIR_RIGHT;
            pending_q   <= 1'b0;
            pend_dir_q  <= DIR_RIGHT;
            pend_grow_q <= 1'b0;
            collision_q <= 1'b0;
            step_ack_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            len_q       <= len_d;
            heading_q   <= heading_d;
            pending_q   <= pending_d;
            pend_dir_q  <= pend_dir_d;
            pend_grow_q <= pend_grow_d;
            collision_q <= collision_d;
            step_ack_q  <= step_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Render pipeline
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]   tile_x_q, tile_x_d;
    logic [COORD_W-1:0]   tile_y_q, tile_y_d;
    logic [TILE_LOG2-1:0] off_x_q, off_x_d;
    logic [TILE_LOG2-1:0] off_y_q, off_y_d;
    logic                 inside_q, inside_d;

    logic [1:0]           fig_q, fig_d;
    logic                 area_q, area_d;
    logic [TILE_LOG2-1:0] x_local_q, x_local_d;
    logic [TILE_LOG2-1:0] y_local_q, y_local_d;

    logic hit_head, hit_body, hit_fruit;

    always_comb begin
        tile_x_d = COORD_W'(X >> TILE_LOG2);
        tile_y_d = COORD_W'(Y >> TILE_LOG2);
        off_x_d  = X[TILE_LOG2-1:0];
        off_y_d  = Y[TILE_LOG2-1:0];
        inside_d = (X < PIX_W) && (Y < PIX_H);
    end

    always_comb begin
        hit_head  = (tile_x_q == seg_x_q[0]) && (tile_y_q == seg_y_q[0]);
        hit_fruit = (tile_x_q == fruit_x) && (tile_y_q == fruit_y);
        hit_body  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < len_q) && (tile_x_q == seg_x_q[i]) && (tile_y_q == seg_y_q[i])) begin
                hit_body = 1'b1;
            end
        end

        fig_d = FIG_EMPTY;
        if (inside_q) begin
            if (hit_head) begin
                fig_d = FIG_HEAD;
            end else if (hit_body) begin
                fig_d = FIG_BODY;
            end else if (hit_fruit) begin
                fig_d = FIG_FRUIT;
            end
        end
        area_d    = inside_q;
        x_local_d = off_x_q;
        y_local_d = off_y_q;
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            tile_x_q  <= '0;
            tile_y_q  <= '0;
            off_x_q   <= '0;
            off_y_q   <= '0;
            inside_q  <= 1'b0;
            fig_q     <= FIG_EMPTY;
            area_q    <= 1'b0;
            x_local_q <= '0;
            y_local_q <= '0;
        end else begin
            tile_x_q  <= tile_x_d;
            tile_y_q  <= tile_y_d;
            off_x_q   <= off_x_d;
            off_y_q   <= off_y_d;
            inside_q  <= inside_d;
            fig_q     <= fig_d;
            area_q    <= area_d;
            x_local_q <= x_local_d;
            y_local_q <= y_local_d;
        end
    end

    assign game_area       = area_q;
    assign selected_figure = fig_q;
    assign x_local         = x_local_q;
    assign y_local         = y_local_q;
    assign snake_head_x    = seg_x_q[0];
    assign snake_head_y    = seg_y_q[0];
    assign snake_length    = len_q;
    assign step_ack        = step_ack_q;
    assign collision       = collision_q;

endmodule
